// File: rtl/i2s_source.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_source
//  Description : I2S transmitter. Takes left/right sample pairs from an
//                upstream FIFO handshake and serialises them as 64-bit frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_source #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int MCLK_PER_BCK = 4
) (
    input  logic                    i2s_master_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sample_clk,
    input  logic                    samples_valid,
    input  logic [SAMPLE_WIDTH-1:0] samples_data,
    output logic                    samples_ready,
    output logic                    bck,
    output logic                    lrck,
    output logic                    sdata,
    output logic                    underflow
);

    localparam int              c_PW      = $clog2(MCLK_PER_BCK);
    localparam logic [c_PW-1:0] c_PH_LAST = c_PW'(MCLK_PER_BCK - 1);
    localparam logic [c_PW-1:0] c_PH_HALF = c_PW'(MCLK_PER_BCK / 2);
    localparam logic [5:0]      c_SW      = 6'(SAMPLE_WIDTH);

    // The FIFO handshake is sampled on the master clock; sample_clk is unused.
    logic w_unused_sample_clk;
    assign w_unused_sample_clk = sample_clk;

    // Frame counter c held as (bit index, phase within the bit).
    logic [5:0]              r_bit;
    logic [c_PW-1:0]         r_ph;
    logic                    r_running;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;
    logic                    r_have_left;
    logic                    r_pair_full;
    logic [SAMPLE_WIDTH-1:0] r_tx_left;
    logic [SAMPLE_WIDTH-1:0] r_tx_right;

    logic                    w_frame_start;
    logic                    w_accept;
    logic [5:0]              w_bit_next;
    logic [c_PW-1:0]         w_ph_next;
    logic [4:0]              w_k;
    logic [5:0]              w_idx;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic [SAMPLE_WIDTH-1:0] w_shifted;
    logic                    w_sdata_next;

    assign samples_ready = enable && !r_pair_full && !reset;
    assign w_accept      = samples_valid && samples_ready;

    always_comb begin
        w_frame_start = enable && (!r_running || (r_bit == 6'd63 && r_ph == c_PH_LAST));
        w_bit_next    = r_bit;
        w_ph_next     = r_ph;
        if (!enable || w_frame_start) begin
            w_bit_next = '0;
            w_ph_next  = '0;
        end else if (r_ph == c_PH_LAST) begin
            w_bit_next = r_bit + 6'd1;
            w_ph_next  = '0;
        end else begin
            w_ph_next = r_ph + c_PW'(1);
        end

        // On a frame-start edge k is 0, so the stale shift words never reach sdata.
        w_k          = w_bit_next[4:0];
        w_idx        = c_SW - {1'b0, w_k};
        w_word       = w_bit_next[5] ? r_tx_right : r_tx_left;
        w_shifted    = w_word >> w_idx;
        w_sdata_next = (w_k != 5'd0) && ({1'b0, w_k} <= c_SW) && w_shifted[0];
    end

    always_ff @(posedge i2s_master_clk) begin
        if (reset || !enable) begin
            r_bit       <= '0;
            r_ph        <= '0;
            r_running   <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_have_left <= 1'b0;
            r_pair_full <= 1'b0;
            r_tx_left   <= '0;
            r_tx_right  <= '0;
            bck         <= 1'b0;
            lrck        <= 1'b0;
            sdata       <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            r_running <= 1'b1;
            r_bit     <= w_bit_next;
            r_ph      <= w_ph_next;
            bck       <= (w_ph_next >= c_PH_HALF);
            lrck      <= w_bit_next[5];
            sdata     <= w_sdata_next;
            underflow <= w_frame_start && !r_pair_full;

            if (w_frame_start) begin
                if (r_pair_full) begin
                    r_tx_left   <= r_left;
                    r_tx_right  <= r_right;
                    r_pair_full <= 1'b0;
                end else begin
                    r_tx_left  <= '0;
                    r_tx_right <= '0;
                end
            end

            // Acceptance cannot coincide with a pair load: ready is low while pair_full.
            if (w_accept) begin
                if (!r_have_left) begin
                    r_left      <= samples_data;
                    r_have_left <= 1'b1;
                end else begin
                    r_right     <= samples_data;
                    r_have_left <= 1'b0;
                    r_pair_full <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_source
//  Description : Scoreboard bench for i2s_source against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_source;

    localparam int SW    = 24;
    localparam int M     = 4;
    localparam int FRAME = 64 * M;

    logic          clk = 1'b0;
    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          valid = 1'b0;
    logic [SW-1:0] data = '0;
    logic          ready, bck, lrck, sdata, uf;

    always #5 clk = ~clk;
    always #23 sclk = ~sclk;

    i2s_source #(
        .SAMPLE_WIDTH(SW),
        .MCLK_PER_BCK(M)
    ) dut (
        .i2s_master_clk(clk),
        .reset         (rst),
        .enable        (en),
        .sample_clk    (sclk),
        .samples_valid (valid),
        .samples_data  (data),
        .samples_ready (ready),
        .bck           (bck),
        .lrck          (lrck),
        .sdata         (sdata),
        .underflow     (uf)
    );

    typedef struct packed {
        logic rdy;
        logic bck;
        logic lrck;
        logic sd;
        logic uf;
    } exp_t;

    exp_t          exp_q[$];
    logic [SW-1:0] src_q[$];
    logic [SW-1:0] pend[$];
    logic [SW-1:0] tx[2];
    int            m_c = 0;
    bit            m_started = 1'b0;
    int            hold_valid = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Upstream FIFO: offers the head of src_q, randomly throttled unless hold_valid.
    always @(negedge clk) begin
        if (src_q.size() > 0 && (hold_valid != 0 || $urandom_range(0, 3) != 0)) begin
            valid = 1'b1;
            data  = src_q[0];
        end else begin
            valid = 1'b0;
            data  = SW'($urandom);
        end
    end

    // Reference model: frame position as an integer, pending pair as a queue.
    always @(posedge clk) begin : model
        exp_t e;
        bit   rdy_before, acc, start;
        int   b, k;
        e          = '0;
        rdy_before = en && !rst && (pend.size() < 2);
        if (rst || !en) begin
            m_c       = 0;
            m_started = 1'b0;
            pend.delete();
            tx[0] = '0;
            tx[1] = '0;
        end else begin
            acc       = valid && rdy_before;
            start     = !m_started || (m_c == FRAME - 1);
            m_c       = start ? 0 : m_c + 1;
            m_started = 1'b1;
            if (start) begin
                if (pend.size() == 2) begin
                    tx[0] = pend[0];
                    tx[1] = pend[1];
                    pend.delete();
                end else begin
                    tx[0] = '0;
                    tx[1] = '0;
                    e.uf  = 1'b1;
                end
            end
            if (acc) begin
                pend.push_back(data);
                void'(src_q.pop_front());
            end
            b      = m_c / M;
            k      = b % 32;
            e.bck  = (m_c % M) >= (M / 2);
            e.lrck = (b >= 32);
            if (k >= 1 && k <= SW)
                e.sd = tx[b / 32][SW - k];
        end
        e.rdy = en && !rst && (pend.size() < 2);
        exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e, act;
        #1;
        act = {ready, bck, lrck, sdata, uf};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty t=%0t got rdy/bck/lrck/sd/uf=%b required an expected entry", $time, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t c=%0d got rdy/bck/lrck/sd/uf=%b required %b",
                         $time, m_c, act, e);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_c(input int target);
        for (int i = 0; i < 2 * FRAME && m_c != target; i++) @(negedge clk);
        n_cmp++;
        if (m_c != target) begin
            n_bad++;
            $display("FAIL wait_c got c=%0d required %0d", m_c, target);
        end
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 8 * FRAME && (src_q.size() != 0 || pend.size() != 0); i++)
            @(negedge clk);
        n_cmp++;
        if (src_q.size() != 0 || pend.size() != 0) begin
            n_bad++;
            $display("FAIL drain got src=%0d pend=%0d required 0/0", src_q.size(), pend.size());
        end
    endtask

    initial begin
        cycles(4);
        rst = 1'b0;
        cycles(2);
        en = 1'b1;
        cycles(2 * FRAME + 10);

        // Directed pair pushed mid-frame, sent in the following frame.
        src_q.push_back(24'h800001);
        src_q.push_back(24'h7FFFFF);
        cycles(2 * FRAME);

        // Continuous valid: a fresh pair every frame.
        hold_valid = 1;
        repeat (10) src_q.push_back(SW'($urandom));
        cycles(5 * FRAME);
        hold_valid = 0;

        // Throttled random stream.
        repeat (6) src_q.push_back(SW'($urandom));
        wait_drained();

        // Left word only, right word one frame later.
        wait_c(10);
        src_q.push_back(24'h123456);
        cycles(FRAME + 20);
        src_q.push_back(24'h000000);
        cycles(2 * FRAME);

        // Disable mid-frame with a pair pending, then restart.
        src_q.push_back(SW'($urandom));
        src_q.push_back(SW'($urandom));
        wait_c(100);
        en = 1'b0;
        cycles(20);
        en = 1'b1;
        cycles(FRAME + 20);

        // Reset mid-frame.
        src_q.push_back(SW'($urandom));
        src_q.push_back(SW'($urandom));
        wait_c(150);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2 * FRAME + 10);

        cycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_source.md
I2S_SOURCE -- requirements
Module: i2s_source

Interface
REQ-001 The parameter SAMPLE_WIDTH SHALL default to 24 and set the audio sample word width in bits (legal range 1..31).
REQ-002 The parameter MCLK_PER_BCK SHALL default to 4 and set the i2s_master_clk cycles per BCK period (even, >=2).
REQ-003 Port i2s_master_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 Port enable  in  1  SHALL be the run enable; when 0 the I2S outputs are idle.
REQ-006 Port sample_clk  in  1  SHALL be accepted for port compatibility and SHALL be ignored; the FIFO handshake is sampled on i2s_master_clk.
REQ-007 Port samples_valid  in  1  SHALL indicate that samples_data holds a word offered by the upstream FIFO.
REQ-008 Port samples_data  in  SAMPLE_WIDTH  SHALL carry the offered sample, two's complement; words alternate left then right.
REQ-009 Port samples_ready  out  1  SHALL indicate that the block accepts the offered word this cycle.
REQ-010 Port bck  out  1  SHALL be the I2S bit clock.
REQ-011 Port lrck  out  1  SHALL be the I2S word select (0 = left, 1 = right).
REQ-012 Port sdata  out  1  SHALL be the I2S serial data, MSB first.
REQ-013 Port underflow  out  1  SHALL pulse for one cycle when a frame starts without a complete sample pair.

Function
REQ-014 The frame counter c SHALL count 0..(64*MCLK_PER_BCK-1), advance by 1 per cycle while enable=1, and wrap to 0.
REQ-015 The bit index b SHALL equal c/MCLK_PER_BCK (0..63).
REQ-016 bck SHALL be 1 when (c mod MCLK_PER_BCK) >= MCLK_PER_BCK/2, else 0; the falling edge falls at the start of each bit and the rising edge falls mid-bit.
REQ-017 lrck SHALL equal bit 5 of b.
REQ-018 Each channel SHALL occupy 32 bits; k = b mod 32.
REQ-019 For k in 1..SAMPLE_WIDTH, sdata SHALL carry bit (SAMPLE_WIDTH-k) of the channel word; for k=0 or k>SAMPLE_WIDTH, sdata SHALL be 0. This gives the I2S one-bit delay after each lrck edge.
REQ-020 bck, lrck and sdata SHALL be registered, and SHALL be computed from the next-state counter so that they reflect the current c with no extra lag.
REQ-021 The block SHALL hold a pending pair: a left register, a right register, a have_left flag and a pair_full flag.
REQ-022 samples_ready SHALL equal enable && !pair_full && !reset.
REQ-023 On valid&&ready with have_left=0, the word SHALL be stored as left and have_left set.
REQ-024 On valid&&ready with have_left=1, the word SHALL be stored as right, have_left cleared and pair_full set.
REQ-025 On the edge where c becomes 0, with pair_full=1, the pair SHALL be copied to the output shift words and pair_full cleared; this frame transmits the pair.
REQ-026 On the edge where c becomes 0, with pair_full=0, the frame SHALL transmit zeros on both channels and underflow SHALL pulse; a pending left word SHALL be retained.
REQ-027 Because ready=0 while pair_full=1, a frame load and an acceptance SHALL never occur on the same edge.
REQ-028 When enable falls, on the next edge c SHALL go to 0, bck/lrck/sdata SHALL go to 0, and the pending pair and flags SHALL be cleared.
REQ-029 The first edge with enable=1 SHALL act as a frame start at c=0, applying REQ-025/026.

Reset
REQ-030 While reset=1, on each edge c, the pending registers, flags and shift words SHALL be cleared, and bck, lrck, sdata, samples_ready and underflow SHALL be 0.
REQ-031 Reset SHALL override enable and the handshake; the first enabled edge after reset SHALL be a frame start.

Verification
REQ-032 Defaults, reset then enable, no valid -> bck period 4 cycles, lrck period 256 cycles, sdata all 0, underflow pulses every 256 cycles.
REQ-033 Push 0x800001 then 0x7FFFFF before the frame start -> left slot sends 1, 22x0, 1 in bits 1..24; right slot sends 0, 23x1; zeros elsewhere; no underflow.
REQ-034 Hold valid high continuously -> ready drops after 2 accepts, rises one cycle after each frame start; every frame is a new pair, with no underflow after the first frame.
REQ-035 Push only a left word (0x123456) -> that frame is zeros with underflow; after the right word (0x000000) arrives, the next frame sends left 0x123456 and right 0x000000.
REQ-036 Deassert enable mid-frame (c=100) then reassert -> outputs 0 while disabled; restart at c=0 with lrck=0; pending data discarded.
REQ-037 Assert reset mid-frame -> all outputs 0 on the next edge, ready=0, and the frame restarts from c=0 after release.
